score_collector: RTL and testbench

SCORE_COLLECTOR -- requirements
Module: score_collector

---
 rtl/score_collector_pkg.sv | 21 ++
 rtl/score_collector.sv | 121 ++++++++++++
 tb/tb_score_collector.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_collector_pkg.sv
// Shared CNN definitions: class count, score width, score type and the
// collector FSM state encoding. The argmax block imports the same package.
package score_collector_pkg;

    localparam int CNN_NUM_CLASSES = 10;
    localparam int CNN_DATA_W      = 54;

    typedef logic signed [CNN_DATA_W-1:0] score_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        RESYNC  = 2'd2
    } collect_state_e;

    // Index counter width; a single-class build still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_collector.sv
// Score collector: gathers NUM_CLASSES serial score beats into one vector,
// emits it with a single-cycle valid pulse, and flags framing violations.
module score_collector
    import score_collector_pkg::*;
#(
    parameter int NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int DATA_W      = CNN_DATA_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_W-1:0]                     s_data,
    input  logic                                  s_last,
    output logic                                  valid_out,
    output logic [NUM_CLASSES-1:0][DATA_W-1:0]    data_out,
    output logic                                  frame_err,
    output logic [15:0]                           frame_cnt
);

    localparam int                IDX_W    = idx_width(NUM_CLASSES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef logic [NUM_CLASSES-1:0][DATA_W-1:0] vec_t;

    collect_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    vec_t             buffer_q, buffer_d;
    vec_t             data_q, data_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             accept;

    // Ready is held low during reset and for the single EMIT cycle.
    assign s_ready = rst_n && (state_q != EMIT);
    assign accept  = s_valid && s_ready;

    // Next-state, buffer write and framing decisions for the collector FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave a variable unassigned and infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        buffer_d = buffer_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    // NOTE: blocking assignment here so the vector copied into
                    // data_d below already contains the beat being accepted.
                    buffer_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            data_d  = buffer_d;
                            state_d = EMIT;
                        end else begin
                            // Long frame: drop it and skip to the next s_last.
                            err_d   = 1'b1;
                            state_d = RESYNC;
                        end
                    end else if (s_last) begin
                        // Short frame: discard what was gathered, start over.
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            EMIT: begin
                cnt_d   = cnt_q + 16'd1;
                idx_d   = '0;
                state_d = COLLECT;
            end

            RESYNC: begin
                if (accept && s_last) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end

            default: begin
                idx_d   = '0;
                state_d = COLLECT;
            end
        endcase
    end

    // State, index, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            // NOTE: the buffer is a storage array yet is reset here, so no
            // stale scores from before reset can ever surface in data_out.
            buffer_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buffer_q <= buffer_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_out = (state_q == EMIT);
    assign frame_err = err_q;
    assign data_out  = data_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_score_collector.sv
// Self-checking bench for score_collector: directed framing scenarios plus
// randomized traffic, compared every cycle against a queue-based frame model.
module tb_score_collector;
    import score_collector_pkg::*;

    localparam int N = CNN_NUM_CLASSES;
    localparam int W = CNN_DATA_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_valid;
    logic                   s_ready;
    logic [W-1:0]           s_data;
    logic                   s_last;
    logic                   valid_out;
    logic [N-1:0][W-1:0]    data_out;
    logic                   frame_err;
    logic [15:0]            frame_cnt;

    score_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .valid_out (valid_out),
        .data_out  (data_out),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [W-1:0] v);
        return 64'($signed(v));
    endfunction

    // Reference model: accepted scores of the current frame, plus flags.
    logic [W-1:0] m_cur[$];
    logic [W-1:0] m_data[N];
    bit           m_resync;
    bit           m_emit;
    bit           m_err;
    logic [15:0]  m_cnt;

    int           cycle = 0;
    int           pulses[$];
    int           err_seen = 0;
    int           last_argmax = -1;
    logic [W-1:0] fb[N];

    function automatic int argmax_dut();
        int best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(data_out[i]) > $signed(data_out[best])) best = i;
        return best;
    endfunction

    task automatic model_reset();
        m_cur.delete();
        for (int i = 0; i < N; i++) m_data[i] = '0;
        m_resync = 0;
        m_emit   = 0;
        m_err    = 0;
        m_cnt    = '0;
    endtask

    task automatic check_outputs();
        check("s_ready", s_ready, !m_emit);
        check("valid_out", valid_out, m_emit);
        check("frame_err", frame_err, m_err);
        check("frame_cnt", frame_cnt, m_cnt);
        for (int i = 0; i < N; i++)
            check($sformatf("data_out[%0d]", i), sx(data_out[i]), sx(m_data[i]));
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit v, input logic [W-1:0] d, input bit l);
        bit nv = 0;
        bit ne = 0;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        check_outputs();
        if (valid_out === 1'b1) begin
            pulses.push_back(cycle);
            last_argmax = argmax_dut();
        end
        if (frame_err === 1'b1) err_seen++;
        if (m_emit) begin
            m_cnt++;
        end else if (v) begin
            if (m_resync) begin
                if (l) m_resync = 0;
            end else begin
                m_cur.push_back(d);
                if (l) begin
                    if (m_cur.size() == N) begin
                        for (int i = 0; i < N; i++) m_data[i] = m_cur[i];
                        nv = 1;
                    end else begin
                        ne = 1;
                    end
                    m_cur.delete();
                end else if (m_cur.size() == N) begin
                    ne = 1;
                    m_resync = 1;
                    m_cur.delete();
                end
            end
        end
        m_emit = nv;
        m_err  = ne;
        cycle++;
    endtask

    // Present one beat with s_valid held high until it is accepted.
    task automatic send_beat(input logic [W-1:0] d, input bit l);
        bit done = 0;
        for (int k = 0; k < 4 && !done; k++) begin
            done = !m_emit;
            step(1, d, l);
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int nbeats, input int last_at);
        logic [63:0] r;
        for (int i = 0; i < nbeats; i++) begin
            r = {$urandom(), $urandom()};
            send_beat((i < N) ? fb[i] : r[W-1:0], i == last_at);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        #1;
        model_reset();
        check("rst_s_ready", s_ready, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        for (int i = 0; i < N; i++) check($sformatf("rst_data[%0d]", i), sx(data_out[i]), 0);
        @(negedge clk);
        check("rst_hold_s_ready", s_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rel_s_ready", s_ready, 1);
    endtask

    task automatic fill_fb_random(input int win, input int win_val);
        for (int i = 0; i < N; i++) fb[i] = W'($urandom_range(0, 400));
        fb[win] = W'(win_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int x;
        logic [63:0] r;
        bit v, l;
        int pos;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        model_reset();
        do_reset();

        // Reference frame: class 3 wins with 100.
        x = 0;
        foreach (fb[i]) fb[i] = '0;
        fb[0] = 10; fb[1] = 20; fb[2] = 5;  fb[3] = 100; fb[4] = 50;
        fb[5] = 12; fb[6] = 80; fb[7] = 45; fb[8] = 1;   fb[9] = 99;
        pulses.delete();
        send_frame(N, N - 1);
        idle(2);
        check("basic_pulses", pulses.size(), 1);
        check("basic_argmax", last_argmax, 3);
        check("basic_cnt", frame_cnt, 1);
        check("basic_d3", sx(data_out[3]), 100);

        // Negative scores: sign must survive.
        for (int i = 0; i < N; i++) fb[i] = W'(-1000);
        fb[7] = W'(-5);
        send_frame(N, N - 1);
        idle(1);
        check("neg_argmax", last_argmax, 7);
        check("neg_d7", sx(data_out[7]), 64'(-5));

        // Back-to-back frames with s_valid held high.
        pulses.delete();
        for (int f = 0; f < 4; f++) begin
            fill_fb_random(f, 500);
            send_frame(N, N - 1);
        end
        idle(2);
        check("b2b_pulses", pulses.size(), 4);
        for (int i = 1; i < pulses.size(); i++)
            check("b2b_gap", pulses[i] - pulses[i-1], N + 1);
        check("b2b_cnt", frame_cnt, 6);

        // Short frame: s_last on beat 4.
        e0 = err_seen;
        pulses.delete();
        fill_fb_random(2, 300);
        send_frame(5, 4);
        idle(2);
        check("short_err", err_seen - e0, 1);
        check("short_no_valid", pulses.size(), 0);
        fill_fb_random(5, 700);
        send_frame(N, N - 1);
        idle(1);
        check("short_recover_argmax", last_argmax, 5);

        // Long frame: 12 beats, s_last on beat 11.
        e0 = err_seen;
        pulses.delete();
        fill_fb_random(1, 900);
        send_frame(12, 11);
        idle(2);
        check("long_err", err_seen - e0, 1);
        check("long_no_valid", pulses.size(), 0);
        fill_fb_random(8, 800);
        send_frame(N, N - 1);
        idle(1);
        check("long_recover_pulses", pulses.size(), 1);
        check("long_recover_argmax", last_argmax, 8);

        // Reset mid-frame after beat 6.
        fill_fb_random(4, 600);
        send_frame(7, -1);
        do_reset();
        fill_fb_random(6, 650);
        send_frame(N, N - 1);
        idle(2);
        check("post_rst_cnt", frame_cnt, 1);
        check("post_rst_argmax", last_argmax, 6);

        // Reset during EMIT: no pulse afterwards.
        fill_fb_random(0, 777);
        send_frame(N, N - 1);
        pulses.delete();
        e0 = err_seen;
        do_reset();
        idle(3);
        check("emit_rst_no_valid", pulses.size(), 0);
        check("emit_rst_no_err", err_seen - e0, 0);

        // Randomized traffic with stalls, framing errors and rare resets.
        for (int c = 0; c < 1500; c++) begin
            v = ($urandom_range(0, 9) < 7);
            pos = m_cur.size();
            if (m_resync)         l = ($urandom_range(0, 3) == 0);
            else if (pos == N - 1) l = ($urandom_range(0, 29) != 0);
            else                  l = ($urandom_range(0, 39) == 0);
            r = {$urandom(), $urandom()};
            step(v, r[W-1:0], l);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
